// File: rtl/gpu_pkg.sv
// gpu_pkg: shared framebuffer geometry, RGB 2:2:2 pixel layout and fill-engine state encoding.
package gpu_pkg;
    localparam int H_RES_DEF = 160;
    localparam int V_RES_DEF = 120;
    localparam int R_HI = 5;
    localparam int R_LO = 4;
    localparam int G_HI = 3;
    localparam int G_LO = 2;
    localparam int B_HI = 1;
    localparam int B_LO = 0;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    typedef enum logic [1:0] {S_IDLE = ST_IDLE, S_FILL = ST_FILL, S_DONE = ST_DONE} fill_state_e;
    function automatic logic [15:0] pix_addr(input logic [7:0] x, input logic [7:0] y);
        return {y, x};
    endfunction
endpackage

// File: rtl/gpu_rect_fill_if.sv
// gpu_rect_fill_if: command handshake plus framebuffer write port of the rectangle fill engine.
interface gpu_rect_fill_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x0;
    logic [7:0]  cmd_x1;
    logic [7:0]  cmd_y0;
    logic [7:0]  cmd_y1;
    logic [7:0]  cmd_color;
    logic        fb_we;
    logic        fb_wready;
    logic [15:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        busy;
    logic        done;
    modport master (
        input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, fb_wready,
        output cmd_ready, fb_we, fb_addr, fb_wdata, busy, done
    );
    modport slave (
        output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, fb_wready,
        input  cmd_ready, fb_we, fb_addr, fb_wdata, busy, done
    );
endinterface

// File: rtl/gpu_rect_fill_rect_norm.sv
// rect_norm: orders rectangle corners, clips them to the screen and flags fully off-screen rectangles.
module rect_norm
    import gpu_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [7:0] y0,
    input  logic [7:0] y1,
    output logic [7:0] xl,
    output logic [7:0] xh,
    output logic [7:0] yl,
    output logic [7:0] yh,
    output logic       off
);
    localparam logic [7:0] X_MAX = 8'(H_RES - 1);
    localparam logic [7:0] Y_MAX = 8'(V_RES - 1);
    logic [7:0] xm;
    logic [7:0] ym;
    always_comb begin
        xl  = x0 < x1 ? x0 : x1;
        xm  = x0 < x1 ? x1 : x0;
        yl  = y0 < y1 ? y0 : y1;
        ym  = y0 < y1 ? y1 : y0;
        xh  = xm > X_MAX ? X_MAX : xm;
        yh  = ym > Y_MAX ? Y_MAX : ym;
        off = xl > X_MAX || yl > Y_MAX;
    end
endmodule

// File: rtl/gpu_rect_fill.sv
// gpu_rect_fill: walks a normalised, clipped rectangle in row-major order, one framebuffer write per accepted cycle.
module gpu_rect_fill
    import gpu_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input logic           clk,
    input logic           rst,
    gpu_rect_fill_if.master bus
);
    logic [1:0] state;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] xl;
    logic [7:0] xh;
    logic [7:0] yh;
    logic [7:0] color;
    logic [7:0] n_xl;
    logic [7:0] n_xh;
    logic [7:0] n_yl;
    logic [7:0] n_yh;
    logic       n_off;
    logic       fill;

    rect_norm #(.H_RES(H_RES), .V_RES(V_RES)) u_norm (
        .x0(bus.cmd_x0), .x1(bus.cmd_x1), .y0(bus.cmd_y0), .y1(bus.cmd_y1),
        .xl(n_xl), .xh(n_xh), .yl(n_yl), .yh(n_yh), .off(n_off)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            x     <= '0;
            y     <= '0;
            xl    <= '0;
            xh    <= '0;
            yh    <= '0;
            color <= '0;
        end else if (state == ST_IDLE) begin
            if (bus.cmd_valid) begin
                state <= n_off ? ST_DONE : ST_FILL;
                x     <= n_xl;
                y     <= n_yl;
                xl    <= n_xl;
                xh    <= n_xh;
                yh    <= n_yh;
                color <= bus.cmd_color;
            end
        end else if (state == ST_FILL) begin
            // counters stop at xh/yh, so the 8-bit increments never wrap
            if (bus.fb_wready) begin
                if (x < xh) begin
                    x <= x + 8'd1;
                end else begin
                    x <= xl;
                    if (y == yh) state <= ST_DONE;
                    else y <= y + 8'd1;
                end
            end
        end else begin
            state <= ST_IDLE;
        end
    end

    assign fill          = state == ST_FILL;
    assign bus.cmd_ready = state == ST_IDLE;
    assign bus.fb_we     = fill;
    assign bus.fb_addr   = fill ? pix_addr(x, y) : 16'h0000;
    assign bus.fb_wdata  = fill ? color : 8'h00;
    assign bus.busy      = state != ST_IDLE;
    assign bus.done      = state == ST_DONE;
endmodule
